// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Magnitudes are multiplied over N steps through a ripple-carry adder; the sign is applied at the end.

module ripple_carry_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[W];

endmodule

module seq_multiplier #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           a_signed,
  input  logic           b_signed,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic           neg;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  count;

  logic [N-1:0]   addend;
  logic [N-1:0]   add_sum;
  logic           add_cout;

  // -2^(N-1) maps onto 2^(N-1), which still fits in N unsigned bits.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic sgn);
    return (sgn & v[N-1]) ? (~v + ONE_N) : v;
  endfunction

  function automatic logic [2*N-1:0] negate(input logic [2*N-1:0] v);
    return ~v + ONE_2N;
  endfunction

  assign addend = mag_b[0] ? mag_a : '0;

  ripple_carry_adder #(.W(N)) u_adder (
    .a    (acc[2*N-1:N]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = S_CALC;
      S_CALC: if (count == LAST_STEP) next_state = S_SIGN;
      S_SIGN: next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mag_a   <= '0;
      mag_b   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mag_a <= magnitude(a, a_signed);
            mag_b <= magnitude(b, b_signed);
            neg   <= (a_signed & a[N-1]) ^ (b_signed & b[N-1]);
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        // Carry-out of the upper-half add lands in the MSB after the shift.
        S_CALC: begin
          acc   <= {add_cout, add_sum, acc[N-1:1]};
          mag_b <= mag_b >> 1;
          count <= count + 1'b1;
        end
        S_SIGN: begin
          product <= neg ? negate(acc) : acc;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        S_DONE: begin
          done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
